// File: rtl/spi_in.sv
// SPI mode-0 receiver: synchronises the host SPI pins into clk_sys, assembles
// bytes MSB first and writes them into the LED frame buffer, pulsing send per frame.
module spi_in #(
   parameter int addr_width = 9,
   parameter int data_width = 8,
   parameter int n_LEDS     = 320
) (
   input  logic                  clk_sys,
   input  logic                  rst,
   input  logic                  n_cs,
   input  logic                  clk_spi,
   input  logic                  sdi,
   output logic [addr_width-1:0] waddr,
   output logic [data_width-1:0] wdata,
   output logic                  we,
   output logic                  send,
   output logic                  frame_err
);

   localparam int BitW  = $clog2(data_width) + 1;
   localparam int ByteW = (n_LEDS > 1) ? $clog2(n_LEDS) : 1;
   localparam logic [BitW-1:0]  LastBit  = BitW'(data_width - 1);
   localparam logic [ByteW-1:0] LastByte = ByteW'(n_LEDS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_t;

   state_t                state_q;
   logic [1:0]            csSync_q;
   logic [1:0]            clkSync_q;
   logic [1:0]            sdiSync_q;
   logic                  clkPrev_q;
   logic [data_width-2:0] shift_q;
   logic [BitW-1:0]       bitCnt_q;
   logic [ByteW-1:0]      byteCnt_q;
   logic [addr_width-1:0] wrPtr_q;
   logic [addr_width-1:0] waddr_q;
   logic [data_width-1:0] wdata_q;
   logic                  we_q;
   logic                  send_q;
   logic                  frameErr_q;

   logic csHigh;
   logic spiRise;
   logic sdiBit;

   // Chip select resets to its inactive (high) level so reset never opens a transaction.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         csSync_q  <= 2'b11;
         clkSync_q <= 2'b00;
         sdiSync_q <= 2'b00;
         clkPrev_q <= 1'b0;
      end else begin
         csSync_q  <= {csSync_q[0], n_cs};
         clkSync_q <= {clkSync_q[0], clk_spi};
         sdiSync_q <= {sdiSync_q[0], sdi};
         clkPrev_q <= clkSync_q[1];
      end
   end

   assign csHigh  = csSync_q[1];
   assign spiRise = clkSync_q[1] & ~clkPrev_q;
   assign sdiBit  = sdiSync_q[1];

   // Outputs are registered on entry to WRITE/DONE so they line up with those states.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bitCnt_q   <= '0;
         byteCnt_q  <= '0;
         wrPtr_q    <= '0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         send_q     <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         we_q       <= 1'b0;
         send_q     <= 1'b0;
         frameErr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               bitCnt_q  <= '0;
               byteCnt_q <= '0;
               if (!csHigh) state_q <= SHIFT;
            end
            SHIFT: begin
               if (csHigh) begin
                  frameErr_q <= (bitCnt_q != '0) || (byteCnt_q != '0);
                  bitCnt_q   <= '0;
                  byteCnt_q  <= '0;
                  state_q    <= IDLE;
               end else if (spiRise) begin
                  shift_q  <= {shift_q[data_width-3:0], sdiBit};
                  bitCnt_q <= bitCnt_q + 1'b1;
                  if (bitCnt_q == LastBit) begin
                     we_q    <= 1'b1;
                     wdata_q <= {shift_q, sdiBit};
                     waddr_q <= wrPtr_q;
                     state_q <= WRITE;
                  end
               end
            end
            // A chip-select release here is handled once back in SHIFT, so the write always lands.
            WRITE: begin
               wrPtr_q  <= wrPtr_q + 1'b1;
               bitCnt_q <= '0;
               if (byteCnt_q == LastByte) begin
                  byteCnt_q <= '0;
                  send_q    <= 1'b1;
                  waddr_q   <= wrPtr_q;
                  state_q   <= DONE;
               end else begin
                  byteCnt_q <= byteCnt_q + 1'b1;
                  state_q   <= SHIFT;
               end
            end
            DONE: begin
               state_q <= csHigh ? IDLE : SHIFT;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign waddr     = waddr_q;
   assign wdata     = wdata_q;
   assign we        = we_q;
   assign send      = send_q;
   assign frame_err = frameErr_q;

endmodule

// File: tb/tb_spi_in.sv
// Directed bench for spi_in: drives SPI bytes from the host side and compares
// the frame-buffer writes, send pulses and frame errors against the sent stream.
module tb_spi_in;

   logic       clk_sys;
   logic       rst;
   logic       n_cs;
   logic       clk_spi;
   logic       sdi;
   logic [8:0] waddr;
   logic [7:0] wdata;
   logic       we;
   logic       send;
   logic       frame_err;

   int testsRun    = 0;
   int testsFailed = 0;
   int cycle       = 0;
   int errCount    = 0;

   int         weAddr[$];
   int         weData[$];
   int         weCycle[$];
   int         sendAddr[$];
   int         sendCycle[$];
   logic [7:0] sentBytes[$];

   spi_in #(.addr_width(9), .data_width(8), .n_LEDS(320)) dut (
      .clk_sys   (clk_sys),
      .rst       (rst),
      .n_cs      (n_cs),
      .clk_spi   (clk_spi),
      .sdi       (sdi),
      .waddr     (waddr),
      .wdata     (wdata),
      .we        (we),
      .send      (send),
      .frame_err (frame_err)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cycle++;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Record every strobe away from the active edge; we/send/frame_err must stay mutually exclusive.
   always @(negedge clk_sys) begin
      if (!rst) begin
         if (we) begin
            weAddr.push_back(int'(waddr));
            weData.push_back(int'(wdata));
            weCycle.push_back(cycle);
         end
         if (send) begin
            sendAddr.push_back(int'(waddr));
            sendCycle.push_back(cycle);
         end
         if (frame_err) errCount++;
         if (we || send || frame_err)
            checkOutput("exclusive", {30'b0, we & send, we & frame_err}, 32'd0);
      end
   end

   task automatic clearMon();
      weAddr.delete();
      weData.delete();
      weCycle.delete();
      sendAddr.delete();
      sendCycle.delete();
      sentBytes.delete();
      errCount = 0;
   endtask

   task automatic applyStimulus(input logic [7:0] value, input int nBits, input int halfNs);
      for (int i = 7; i >= 8 - nBits; i--) begin
         sdi = value[i];
         #halfNs;
         clk_spi = 1'b1;
         #halfNs;
         clk_spi = 1'b0;
      end
      if (nBits == 8) sentBytes.push_back(value);
   endtask

   task automatic sendBytes(input int count, input int mult, input int add, input int halfNs);
      for (int i = 0; i < count; i++)
         applyStimulus(8'((i * mult + add) % 256), 8, halfNs);
   endtask

   task automatic startTxn();
      @(posedge clk_sys);
      #2;
      n_cs = 1'b0;
      repeat (4) @(posedge clk_sys);
      #2;
   endtask

   task automatic endTxn();
      repeat (10) @(posedge clk_sys);
      #2;
      n_cs = 1'b1;
      repeat (10) @(posedge clk_sys);
      #2;
   endtask

   task automatic doReset();
      @(posedge clk_sys);
      #2;
      rst = 1'b1;
      repeat (2) @(posedge clk_sys);
      #2;
      rst = 1'b0;
      repeat (2) @(posedge clk_sys);
      #2;
      clearMon();
   endtask

   task automatic checkWrites(input string tag, input int startAddr);
      int n;
      checkOutput({tag, "_weCount"}, weAddr.size(), sentBytes.size());
      n = (weAddr.size() < sentBytes.size()) ? weAddr.size() : sentBytes.size();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s_addr%0d", tag, i), weAddr[i], (startAddr + i) % 512);
         checkOutput($sformatf("%s_data%0d", tag, i), weData[i], int'(sentBytes[i]));
      end
   endtask

   initial begin
      rst     = 1'b1;
      n_cs    = 1'b1;
      clk_spi = 1'b0;
      sdi     = 1'b0;
      repeat (3) @(posedge clk_sys);
      #2;
      checkOutput("rst_waddr", waddr, 0);
      checkOutput("rst_wdata", wdata, 0);
      checkOutput("rst_we", we, 0);
      checkOutput("rst_send", send, 0);
      checkOutput("rst_frameErr", frame_err, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk_sys);
      #2;
      clearMon();

      // Single byte then release: one write at 0, partial frame error, no send
      startTxn();
      applyStimulus(8'hA5, 8, 40);
      endTxn();
      checkWrites("single", 0);
      checkOutput("single_errs", errCount, 1);
      checkOutput("single_sends", sendAddr.size(), 0);

      // Full frame from address 0
      doReset();
      startTxn();
      sendBytes(320, 1, 0, 30);
      endTxn();
      checkWrites("frame", 0);
      checkOutput("frame_sends", sendAddr.size(), 1);
      if (sendAddr.size() >= 1) checkOutput("frame_sendAddr", sendAddr[0], 319);
      if (sendCycle.size() >= 1 && weCycle.size() == 320)
         checkOutput("frame_sendTiming", sendCycle[0], weCycle[319] + 1);
      checkOutput("frame_errs", errCount, 0);

      // Two frames back-to-back at the minimum 4:1 clock ratio, wrapping the pointer
      doReset();
      startTxn();
      sendBytes(640, 3, 1, 20);
      endTxn();
      checkWrites("wrap", 0);
      checkOutput("wrap_sends", sendAddr.size(), 2);
      if (sendAddr.size() >= 2) begin
         checkOutput("wrap_sendAddr0", sendAddr[0], 319);
         checkOutput("wrap_sendAddr1", sendAddr[1], 127);
      end
      checkOutput("wrap_errs", errCount, 0);

      // Partial byte abort leaves the write pointer at 128
      clearMon();
      startTxn();
      applyStimulus(8'hFF, 5, 20);
      endTxn();
      checkOutput("partial_we", weAddr.size(), 0);
      checkOutput("partial_errs", errCount, 1);
      clearMon();
      startTxn();
      applyStimulus(8'h3C, 8, 20);
      endTxn();
      checkWrites("afterAbort", 128);
      checkOutput("afterAbort_errs", errCount, 1);

      // Reset in the middle of a frame: outputs clear at once, next frame restarts at 0
      clearMon();
      startTxn();
      sendBytes(100, 5, 7, 20);
      repeat (5) @(posedge clk_sys);
      #2;
      checkWrites("midFrame", 129);
      checkOutput("midFrame_waddr", waddr, 228);
      rst = 1'b1;
      #1;
      checkOutput("midRst_waddr", waddr, 0);
      checkOutput("midRst_wdata", wdata, 0);
      checkOutput("midRst_we", we, 0);
      checkOutput("midRst_send", send, 0);
      checkOutput("midRst_frameErr", frame_err, 0);
      #1;
      n_cs = 1'b1;
      repeat (3) @(posedge clk_sys);
      #2;
      rst = 1'b0;
      repeat (2) @(posedge clk_sys);
      #2;
      clearMon();
      startTxn();
      sendBytes(320, 7, 3, 20);
      endTxn();
      checkWrites("postRst", 0);
      checkOutput("postRst_sends", sendAddr.size(), 1);
      if (sendAddr.size() >= 1) checkOutput("postRst_sendAddr", sendAddr[0], 319);
      checkOutput("postRst_errs", errCount, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
